hit_judge: RTL and testbench

Per-frame collision referee between the heart (player hitbox) and the two bullet descriptors produced by the bullet generator. On each frame strobe it snapshots both bullets and the heart, tests each bullet for overlap with one time-shared comparator, and applies colour rules to update the player's HP. It also returns the one-cycle `isCollide` pulse that the bullet generator consumes.

---
 rtl/undertale_pkg.sv | 45 ++++
 rtl/aabb_overlap.sv | 37 +++
 rtl/hit_judge.sv | 165 ++++++++++++++++
 tb/tb_hit_judge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/undertale_pkg.sv
// rtl/undertale_pkg.sv - shared colour, field-slice and FSM definitions for the bullet/heart blocks
package undertale_pkg;

  localparam logic [2:0] COLOR_WHITE = 3'b000;
  localparam logic [2:0] COLOR_GREEN = 3'b001;
  localparam logic [2:0] COLOR_BLUE  = 3'b010;

  // position packs {x, y}; size packs {w, h}
  localparam int POS_X_MSB  = 15;
  localparam int POS_X_LSB  = 8;
  localparam int POS_Y_MSB  = 7;
  localparam int POS_Y_LSB  = 0;
  localparam int SIZE_W_MSB = 15;
  localparam int SIZE_W_LSB = 8;
  localparam int SIZE_H_MSB = 7;
  localparam int SIZE_H_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHK1  = 2'd1,
    ST_CHK2  = 2'd2,
    ST_APPLY = 2'd3
  } judge_state_t;

  typedef struct packed {
    logic [15:0] pos;
    logic [15:0] size;
    logic [2:0]  color;
    logic        render;
  } bullet_t;

  // Blue only hurts a moving heart; reserved colours are harmless.
  function automatic logic hit_qualifies(input logic [2:0] color, input logic moving);
    case (color)
      COLOR_WHITE, COLOR_GREEN: hit_qualifies = 1'b1;
      COLOR_BLUE:               hit_qualifies = moving;
      default:                  hit_qualifies = 1'b0;
    endcase
  endfunction

  function automatic logic is_damaging(input logic [2:0] color);
    is_damaging = (color == COLOR_WHITE) || (color == COLOR_BLUE);
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - strict axis-aligned box overlap test, combinational
module aabb_overlap
  import undertale_pkg::*;
(
  input  logic [15:0] a_pos,
  input  logic [15:0] a_size,
  input  logic [15:0] b_pos,
  input  logic [15:0] b_size,
  output logic        overlap
);

  logic [7:0] ax, ay, aw, ah, bx, by, bw, bh;
  logic [8:0] a_x_end, a_y_end, b_x_end, b_y_end;
  logic       nonzero;

  assign ax = a_pos[POS_X_MSB:POS_X_LSB];
  assign ay = a_pos[POS_Y_MSB:POS_Y_LSB];
  assign aw = a_size[SIZE_W_MSB:SIZE_W_LSB];
  assign ah = a_size[SIZE_H_MSB:SIZE_H_LSB];
  assign bx = b_pos[POS_X_MSB:POS_X_LSB];
  assign by = b_pos[POS_Y_MSB:POS_Y_LSB];
  assign bw = b_size[SIZE_W_MSB:SIZE_W_LSB];
  assign bh = b_size[SIZE_H_MSB:SIZE_H_LSB];

  // 9-bit far edges so a box near 255 never wraps back to the origin
  assign a_x_end = {1'b0, ax} + {1'b0, aw};
  assign a_y_end = {1'b0, ay} + {1'b0, ah};
  assign b_x_end = {1'b0, bx} + {1'b0, bw};
  assign b_y_end = {1'b0, by} + {1'b0, bh};

  assign nonzero = (aw != 8'd0) && (ah != 8'd0) && (bw != 8'd0) && (bh != 8'd0);

  assign overlap = nonzero
                && ({1'b0, ax} < b_x_end) && ({1'b0, bx} < a_x_end)
                && ({1'b0, ay} < b_y_end) && ({1'b0, by} < a_y_end);

endmodule

// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - per-frame heart/bullet collision referee and HP keeper
module hit_judge
  import undertale_pkg::*;
#(
  parameter int HP_MAX     = 20,
  parameter int DAMAGE     = 4,
  parameter int HEAL       = 1,
  parameter int INV_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frameTick,
  input  logic        isRun,
  input  logic [15:0] heartPos,
  input  logic [15:0] heartSize,
  input  logic        heartMoving,
  input  logic [15:0] position1,
  input  logic [15:0] size1,
  input  logic [2:0]  color1,
  input  logic        isRender1,
  input  logic [15:0] position2,
  input  logic [15:0] size2,
  input  logic [2:0]  color2,
  input  logic        isRender2,
  output logic        isCollide,
  output logic [1:0]  hitMask,
  output logic [7:0]  hp,
  output logic        invincible,
  output logic        isDead
);

  localparam logic [7:0] HP_MAX_L = 8'(HP_MAX);
  localparam logic [7:0] DAMAGE_L = 8'(DAMAGE);
  localparam logic [8:0] HEAL_L   = 9'(HEAL);
  localparam logic [7:0] INV_L    = 8'(INV_FRAMES);

  judge_state_t state_q, state_d;
  bullet_t      b1_q, b1_d, b2_q, b2_d;
  logic [15:0]  heart_pos_q, heart_pos_d, heart_size_q, heart_size_d;
  logic         moving_q, moving_d;
  logic         hit1_q, hit1_d, hit2_q, hit2_d;
  logic         dmg1_q, dmg1_d, dmg2_q, dmg2_d;
  logic [7:0]   hp_q, hp_d, inv_q, inv_d;
  logic         dead_q, dead_d, collide_q, collide_d;
  logic [1:0]   mask_q, mask_d;

  bullet_t      sel_b;
  logic         overlap, sel_hit, damaging;
  logic [8:0]   heal_sum;

  // One comparator, time-shared: CHK1 looks at bullet 1, CHK2 at bullet 2
  assign sel_b = (state_q == ST_CHK1) ? b1_q : b2_q;

  aabb_overlap u_aabb (
    .a_pos   (sel_b.pos),
    .a_size  (sel_b.size),
    .b_pos   (heart_pos_q),
    .b_size  (heart_size_q),
    .overlap (overlap)
  );

  assign sel_hit  = sel_b.render && overlap && hit_qualifies(sel_b.color, moving_q);
  assign damaging = dmg1_q || dmg2_q;
  assign heal_sum = {1'b0, hp_q} + HEAL_L;

  always_comb begin
    state_d      = state_q;
    b1_d         = b1_q;
    b2_d         = b2_q;
    heart_pos_d  = heart_pos_q;
    heart_size_d = heart_size_q;
    moving_d     = moving_q;
    hit1_d       = hit1_q;
    hit2_d       = hit2_q;
    dmg1_d       = dmg1_q;
    dmg2_d       = dmg2_q;
    hp_d         = hp_q;
    inv_d        = inv_q;
    dead_d       = dead_q;
    collide_d    = 1'b0;
    mask_d       = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (frameTick && isRun && !dead_q) begin
          b1_d         = '{pos: position1, size: size1, color: color1, render: isRender1};
          b2_d         = '{pos: position2, size: size2, color: color2, render: isRender2};
          heart_pos_d  = heartPos;
          heart_size_d = heartSize;
          moving_d     = heartMoving;
          state_d      = ST_CHK1;
        end
      end
      ST_CHK1: begin
        hit1_d  = sel_hit;
        dmg1_d  = sel_hit && is_damaging(sel_b.color);
        state_d = ST_CHK2;
      end
      ST_CHK2: begin
        hit2_d  = sel_hit;
        dmg2_d  = sel_hit && is_damaging(sel_b.color);
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        collide_d = hit1_q || hit2_q;
        mask_d    = {hit2_q, hit1_q};
        if (damaging && (inv_q == 8'd0)) begin
          hp_d  = (hp_q > DAMAGE_L) ? (hp_q - DAMAGE_L) : 8'd0;
          inv_d = INV_L;
        end else if (inv_q != 8'd0) begin
          inv_d = inv_q - 8'd1;
        end
        // Green heals even through invincibility, but never alongside damage
        if (!damaging && (hit1_q || hit2_q)) begin
          hp_d = (heal_sum > {1'b0, HP_MAX_L}) ? HP_MAX_L : heal_sum[7:0];
        end
        dead_d  = (hp_d == 8'd0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      b1_q         <= '0;
      b2_q         <= '0;
      heart_pos_q  <= '0;
      heart_size_q <= '0;
      moving_q     <= 1'b0;
      hit1_q       <= 1'b0;
      hit2_q       <= 1'b0;
      dmg1_q       <= 1'b0;
      dmg2_q       <= 1'b0;
      hp_q         <= HP_MAX_L;
      inv_q        <= 8'd0;
      dead_q       <= 1'b0;
      collide_q    <= 1'b0;
      mask_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      heart_pos_q  <= heart_pos_d;
      heart_size_q <= heart_size_d;
      moving_q     <= moving_d;
      hit1_q       <= hit1_d;
      hit2_q       <= hit2_d;
      dmg1_q       <= dmg1_d;
      dmg2_q       <= dmg2_d;
      hp_q         <= hp_d;
      inv_q        <= inv_d;
      dead_q       <= dead_d;
      collide_q    <= collide_d;
      mask_q       <= mask_d;
    end
  end

  assign isCollide  = collide_q;
  assign hitMask    = mask_q;
  assign hp         = hp_q;
  assign invincible = (inv_q != 8'd0);
  assign isDead     = dead_q;

endmodule

// File: tb/tb_hit_judge.sv
// tb/tb_hit_judge.sv - scoreboard bench for hit_judge against a frame-level reference model
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frameTick = 1'b0;
  logic        isRun = 1'b0;
  logic [15:0] heartPos = '0, heartSize = '0;
  logic        heartMoving = 1'b0;
  logic [15:0] position1 = '0, size1 = '0, position2 = '0, size2 = '0;
  logic [2:0]  color1 = '0, color2 = '0;
  logic        isRender1 = 1'b0, isRender2 = 1'b0;
  logic        isCollide;
  logic [1:0]  hitMask;
  logic [7:0]  hp;
  logic        invincible, isDead;

  hit_judge dut (
    .clk(clk), .rst_n(rst_n), .frameTick(frameTick), .isRun(isRun),
    .heartPos(heartPos), .heartSize(heartSize), .heartMoving(heartMoving),
    .position1(position1), .size1(size1), .color1(color1), .isRender1(isRender1),
    .position2(position2), .size2(size2), .color2(color2), .isRender2(isRender2),
    .isCollide(isCollide), .hitMask(hitMask), .hp(hp),
    .invincible(invincible), .isDead(isDead)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] mask;
    int         hp;
    int         inv;
    int         dead;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  int m_hp = 20;
  int m_inv = 0;
  bit m_dead = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic bit boxes_overlap(input logic [15:0] p, input logic [15:0] s,
                                       input logic [15:0] q, input logic [15:0] t);
    int bx, by, bw, bh, hx, hy, hw, hh;
    bx = int'(p[15:8]); by = int'(p[7:0]); bw = int'(s[15:8]); bh = int'(s[7:0]);
    hx = int'(q[15:8]); hy = int'(q[7:0]); hw = int'(t[15:8]); hh = int'(t[7:0]);
    if (bw == 0 || bh == 0 || hw == 0 || hh == 0) return 1'b0;
    return (bx < hx + hw) && (hx < bx + bw) && (by < hy + hh) && (hy < by + bh);
  endfunction

  function automatic bit qualifies(input bit render, input logic [2:0] c, input bit ov, input bit moving);
    return render && ov && (c == 3'd0 || c == 3'd1 || (c == 3'd2 && moving));
  endfunction

  // Frame-level rules: who hit, whether it hurts, HP and invincibility bookkeeping
  task automatic model_frame(output bit pulse, output logic [1:0] mask);
    bit q1, q2, d1, d2, dmg;
    pulse = 1'b0;
    mask  = 2'b00;
    if (m_dead) return;
    q1 = qualifies(isRender1, color1, boxes_overlap(position1, size1, heartPos, heartSize), heartMoving);
    q2 = qualifies(isRender2, color2, boxes_overlap(position2, size2, heartPos, heartSize), heartMoving);
    d1 = q1 && (color1 != 3'd1);
    d2 = q2 && (color2 != 3'd1);
    dmg = d1 || d2;
    pulse = q1 || q2;
    mask = {q2, q1};
    if (dmg && m_inv == 0) begin
      m_hp = (m_hp - 4 < 0) ? 0 : m_hp - 4;
      m_inv = 30;
    end else if (m_inv != 0) begin
      m_inv = m_inv - 1;
    end
    if (!dmg && pulse) m_hp = (m_hp + 1 > 20) ? 20 : m_hp + 1;
    m_dead = (m_hp == 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (isCollide) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pulse: isCollide=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("hitMask", int'(hitMask), int'(e.mask));
        check("pulse_hp", int'(hp), e.hp);
        check("pulse_invincible", int'(invincible), e.inv);
        check("pulse_isDead", int'(isDead), e.dead);
      end
    end
  end

  task automatic set_heart(input logic [15:0] p, input logic [15:0] s, input logic mv);
    heartPos = p; heartSize = s; heartMoving = mv;
  endtask

  task automatic set_b1(input logic [15:0] p, input logic [15:0] s, input logic [2:0] c, input logic r);
    position1 = p; size1 = s; color1 = c; isRender1 = r;
  endtask

  task automatic set_b2(input logic [15:0] p, input logic [15:0] s, input logic [2:0] c, input logic r);
    position2 = p; size2 = s; color2 = c; isRender2 = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_hp = 20; m_inv = 0; m_dead = 1'b0;
    sb.delete();
  endtask

  // Inputs are scrambled while the frame is in flight, then restored
  task automatic do_frame(input bit run);
    bit pulse;
    logic [1:0] mask;
    exp_t e;
    logic [15:0] s_hp, s_hs, s_p1, s_s1, s_p2, s_s2;
    logic [2:0] s_c1, s_c2;
    logic s_mv, s_r1, s_r2;
    if (run) model_frame(pulse, mask);
    else pulse = 1'b0;
    if (pulse) begin
      e.mask = mask; e.hp = m_hp; e.inv = (m_inv != 0); e.dead = m_dead; e.cyc = cyc + 4;
      sb.push_back(e);
    end
    s_hp = heartPos; s_hs = heartSize; s_mv = heartMoving;
    s_p1 = position1; s_s1 = size1; s_c1 = color1; s_r1 = isRender1;
    s_p2 = position2; s_s2 = size2; s_c2 = color2; s_r2 = isRender2;
    isRun = run;
    frameTick = 1'b1;
    @(negedge clk);
    frameTick = 1'b0;
    isRun = 1'b1;
    heartPos = 16'($urandom); heartSize = 16'($urandom); heartMoving = 1'($urandom);
    position1 = 16'($urandom); size1 = 16'($urandom); color1 = 3'($urandom); isRender1 = 1'($urandom);
    position2 = 16'($urandom); size2 = 16'($urandom); color2 = 3'($urandom); isRender2 = 1'($urandom);
    repeat (5) @(negedge clk);
    check("hp", int'(hp), m_hp);
    check("invincible", int'(invincible), int'(m_inv != 0));
    check("isDead", int'(isDead), int'(m_dead));
    check("hitMask_idle", int'(hitMask), 0);
    check("pulse_missing", sb.size(), 0);
    sb.delete();
    heartPos = s_hp; heartSize = s_hs; heartMoving = s_mv;
    position1 = s_p1; size1 = s_s1; color1 = s_c1; isRender1 = s_r1;
    position2 = s_p2; size2 = s_s2; color2 = s_c2; isRender2 = s_r2;
  endtask

  initial begin
    logic [7:0] hx, hy;
    isRun = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_hp", int'(hp), 20);
    check("reset_isCollide", int'(isCollide), 0);
    check("reset_hitMask", int'(hitMask), 0);
    check("reset_invincible", int'(invincible), 0);
    check("reset_isDead", int'(isDead), 0);

    set_heart(16'h6464, 16'h1010, 1'b0);
    set_b1(16'h6E6E, 16'h0808, 3'd0, 1'b1);
    set_b2(16'h0000, 16'h0000, 3'd0, 1'b0);
    do_frame(1'b1);
    check("basic_hp", int'(hp), 16);
    check("basic_invincible", int'(invincible), 1);
    set_b1(16'h746E, 16'h0808, 3'd0, 1'b1);
    do_frame(1'b1);
    set_b1(16'h6E6E, 16'h0008, 3'd0, 1'b1);
    do_frame(1'b1);

    do_reset();
    set_b1(16'h6E6E, 16'h0808, 3'd2, 1'b1);
    do_frame(1'b1);
    heartMoving = 1'b1;
    do_frame(1'b1);
    check("blue_moving_hp", int'(hp), 16);

    do_reset();
    set_heart(16'h6464, 16'h1010, 1'b0);
    set_b1(16'h6E6E, 16'h0808, 3'd0, 1'b1);
    set_b2(16'h6060, 16'h0808, 3'd0, 1'b1);
    do_frame(1'b1);
    check("double_hp", int'(hp), 16);
    for (int i = 0; i < 31; i++) do_frame(1'b1);
    check("reinvuln_hp", int'(hp), 12);

    set_b1(16'h6E6E, 16'h0808, 3'd1, 1'b1);
    set_b2(16'h0000, 16'h0808, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) do_frame(1'b1);
    check("heal_saturate_hp", int'(hp), 20);

    set_b1(16'h6E6E, 16'h0808, 3'd0, 1'b1);
    for (int i = 0; i < 200 && !m_dead; i++) do_frame(1'b1);
    check("death_isDead", int'(isDead), 1);
    check("death_hp", int'(hp), 0);
    for (int i = 0; i < 3; i++) do_frame(1'b1);

    do_reset();
    set_heart(16'h6464, 16'h1010, 1'b0);
    set_b1(16'h6E6E, 16'h0808, 3'd0, 1'b1);
    frameTick = 1'b1;
    @(negedge clk);
    frameTick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_hp", int'(hp), 20);
    check("midreset_invincible", int'(invincible), 0);
    check("midreset_hitMask", int'(hitMask), 0);
    do_frame(1'b1);
    check("after_reset_hp", int'(hp), 16);
    do_frame(1'b0);

    for (int i = 0; i < 300; i++) begin
      if (m_dead) do_reset();
      hx = 8'($urandom_range(0, 255));
      hy = 8'($urandom_range(0, 255));
      set_heart({hx, hy}, {8'($urandom_range(0, 24)), 8'($urandom_range(0, 24))}, 1'($urandom));
      set_b1({hx + 8'($urandom_range(0, 40)) - 8'd20, hy + 8'($urandom_range(0, 40)) - 8'd20},
             {8'($urandom_range(0, 16)), 8'($urandom_range(0, 16))},
             ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)), 1'($urandom_range(0, 3) != 0));
      set_b2({hx + 8'($urandom_range(0, 40)) - 8'd20, hy + 8'($urandom_range(0, 40)) - 8'd20},
             {8'($urandom_range(0, 16)), 8'($urandom_range(0, 16))},
             ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)), 1'($urandom_range(0, 3) != 0));
      do_frame($urandom_range(0, 9) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
